// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR sequencer.
// Holds the default geometry, the sequencer state type and the circular
// buffer index helper used to walk the tap history backwards in time.
package fir_pkg;

  localparam int unsigned DEF_NTAPS  = 9;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_COEF_W = 8;
  localparam int unsigned DEF_ACC_W  = 20;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } fir_seq_state_t;

  // Index of sample x[n-k] when x[n] sits at slot 'base' of an ntaps-deep
  // circular buffer. k is always < ntaps, so a single conditional wrap
  // replaces a general modulo.
  function automatic int unsigned tap_idx(int unsigned base, int unsigned k,
                                          int unsigned ntaps = DEF_NTAPS);
    return (base >= k) ? (base - k) : (base + ntaps - k);
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Single shared multiply-accumulate for the FIR sequencer.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr_i     : load zero into the accumulator (wins over en_i)
//   en_i      : add a_i*b_i into the accumulator
//   a_i, b_i  : unsigned operands
//   acc_o     : registered accumulator value
module fir_mac_unit #(
  parameter int unsigned A_W   = 8,
  parameter int unsigned B_W   = 8,
  parameter int unsigned ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [A_W-1:0]   a_i,
  input  logic [B_W-1:0]   b_i,
  output logic [ACC_W-1:0] acc_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] prod;

  // Operands are zero-extended first so the product is formed at full
  // accumulator width; ACC_W is sized so neither product nor sum can wrap.
  // NOTE: every signal written here gets a value before any branch, so the
  // block stays purely combinational and no latch is inferred.
  always_comb begin
    prod  = ACC_W'(a_i) * ACC_W'(b_i);
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples values from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: accepts one sample per handshake into a
// circular tap history, runs NTAPS multiply-accumulate cycles through one
// shared MAC, then presents the full-precision sum on a valid/ready output.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : sample handshake, data_in is the sample
//   out_valid/out_ready  : result handshake, data_out is the filter sum
//   coef_we/addr/data    : coefficient write port (honoured only when idle)
//   clear                : zero the whole sample history in one cycle
//   busy                 : sequencer is not idle
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter  int unsigned NTAPS  = DEF_NTAPS,
  parameter  int unsigned DATA_W = DEF_DATA_W,
  parameter  int unsigned COEF_W = DEF_COEF_W,
  parameter  int unsigned ACC_W  = DEF_ACC_W,
  localparam int unsigned AW     = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  data_out,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              clear,
  output logic              busy
);

  fir_seq_state_t state_q, state_d;

  logic [DATA_W-1:0] hist_q [NTAPS];
  logic [COEF_W-1:0] coef_q [NTAPS];
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     base_q;
  logic [AW-1:0]     k_q, k_d;
  logic [ACC_W-1:0]  dout_q;
  logic [ACC_W-1:0]  acc;
  logic [AW-1:0]     rd_idx;
  logic              accept;
  logic              handshake;
  logic              mac_clr;
  logic              mac_en;
  logic              idle_ready;

  // History slot holding x[n-k] for the tap currently being accumulated.
  assign rd_idx = AW'(tap_idx(32'(base_q), 32'(k_q), NTAPS));

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    idle_ready = !coef_we && !clear;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    handshake  = 1'b0;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = idle_ready;
        if (in_valid && idle_ready) begin
          accept  = 1'b1;
          mac_clr = 1'b1;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (k_q == AW'(NTAPS - 1)) begin
          state_d = OUT;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          handshake = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: history and coefficients are small flop arrays rather than RAM
  // macros, so they can and must be reset to zero alongside the control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NTAPS); i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
      state_q <= IDLE;
      wptr_q  <= '0;
      base_q  <= '0;
      k_q     <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      // Coefficient write beats clear, which beats a sample; both are
      // ignored outside IDLE, and out-of-range addresses are dropped.
      if (state_q == IDLE && coef_we) begin
        if (32'(coef_addr) < NTAPS) begin
          coef_q[coef_addr] <= coef_data;
        end
      end else if (state_q == IDLE && clear) begin
        for (int i = 0; i < int'(NTAPS); i++) begin
          hist_q[i] <= '0;
        end
      end
      if (accept) begin
        hist_q[wptr_q] <= data_in;
        base_q         <= wptr_q;
        wptr_q         <= (wptr_q == AW'(NTAPS - 1)) ? '0 : wptr_q + AW'(1);
      end
      // The result is captured at consumption so data_out survives the
      // accumulator clear of the next accepted sample.
      if (handshake) begin
        dout_q <= acc;
      end
    end
  end

  fir_mac_unit #(
    .A_W   (DATA_W),
    .B_W   (COEF_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (hist_q[rd_idx]),
    .b_i   (coef_q[k_q]),
    .acc_o (acc)
  );

  // While presenting, the accumulator is frozen and is the result itself.
  assign data_out = (state_q == OUT) ? acc : dout_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer (NTAPS=9, 8-bit data/coef,
// 20-bit result). The reference model keeps the newest NTAPS samples in a
// shift list and forms sum coef[k]*x[n-k] directly.
module tb_fir_mac_sequencer;

  localparam int NTAPS  = 9;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int ACC_W  = 20;
  localparam int AW     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  data_out;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              clear;
  logic              busy;

  fir_mac_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .clear     (clear),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned coef_m [NTAPS];
  int unsigned hist_m [NTAPS];  // hist_m[j] = x[n-j]

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned model_out();
    int unsigned s = 0;
    for (int k = 0; k < NTAPS; k++) s += coef_m[k] * hist_m[k];
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NTAPS; k++) begin
      coef_m[k] = 0;
      hist_m[k] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in IDLE with all control inputs low.
  task automatic write_coef(input int a, input int unsigned d);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = COEF_W'(d);
    tick();
    coef_we = 1'b0;
    if (a < NTAPS) coef_m[a] = d;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < NTAPS; k++) hist_m[k] = 0;
  endtask

  // Feeds one sample from IDLE, checks latency and result, holds the result
  // for 'stall' cycles, then consumes it. With 'noise' set, random writes and
  // samples are driven while the sequencer is busy and must be ignored.
  task automatic run_sample(input int unsigned d, input int stall, input bit noise,
                            output int unsigned got);
    int unsigned exp;
    int lat;
    in_valid = 1'b1;
    data_in  = DATA_W'(d);
    #1;
    check("in_ready_idle", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    for (int j = NTAPS - 1; j > 0; j--) hist_m[j] = hist_m[j-1];
    hist_m[0] = d;
    exp = model_out();
    check("busy_in_mac", 64'(busy), 64'(1));
    check("in_ready_in_mac", 64'(in_ready), 64'(0));
    lat = 0;
    while (out_valid !== 1'b1 && lat < NTAPS + 4) begin
      if (noise) begin
        in_valid  = 1'($urandom_range(0, 1));
        data_in   = DATA_W'($urandom);
        coef_we   = 1'($urandom_range(0, 1));
        coef_addr = AW'($urandom_range(0, NTAPS - 1));
        coef_data = COEF_W'($urandom);
      end
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(NTAPS));
    check("result", 64'(data_out), 64'(exp));
    got = 32'(data_out);
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_valid", 64'(out_valid), 64'(1));
      check("stall_data", 64'(data_out), 64'(exp));
      check("stall_in_ready", 64'(in_ready), 64'(0));
    end
    in_valid  = 1'b0;
    coef_we   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    check("post_hs_valid", 64'(out_valid), 64'(0));
    check("post_hs_busy", 64'(busy), 64'(0));
    check("post_hs_in_ready", 64'(in_ready), 64'(1));
    check("post_hs_hold", 64'(data_out), 64'(exp));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned got;
    rst       = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    clear     = 1'b0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_data_out", 64'(data_out), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Impulse response equals the coefficient list.
    for (int k = 0; k < NTAPS; k++) write_coef(k, k + 1);
    for (int i = 0; i < NTAPS; i++) begin
      run_sample((i == 0) ? 1 : 0, 0, 1'b0, got);
      check("impulse", 64'(got), 64'(i + 1));
    end

    // Full-scale input: largest possible sum must not wrap.
    for (int k = 0; k < NTAPS; k++) write_coef(k, 255);
    for (int i = 0; i < NTAPS; i++) run_sample(255, 0, 1'b0, got);
    check("full_scale", 64'(got), 64'(585225));

    // Output held under back-pressure, busy-time inputs ignored.
    run_sample(17, 5, 1'b1, got);

    // Coefficient write and sample offered together: write first.
    coef_we   = 1'b1;
    coef_addr = AW'(0);
    coef_data = COEF_W'(3);
    in_valid  = 1'b1;
    data_in   = DATA_W'(4);
    #1;
    check("we_blocks_ready", 64'(in_ready), 64'(0));
    tick();
    coef_we   = 1'b0;
    coef_m[0] = 3;
    #1;
    check("we_no_accept", 64'(busy), 64'(0));
    run_sample(4, 0, 1'b0, got);

    // Clear wipes every older tap.
    for (int k = 1; k < NTAPS; k++) write_coef(k, $urandom_range(1, 255));
    write_coef(0, 2);
    for (int i = 0; i < NTAPS; i++) run_sample(7, 0, 1'b0, got);
    do_clear();
    run_sample(3, 0, 1'b0, got);
    check("after_clear", 64'(got), 64'(6));

    // Reset during the 4th MAC cycle abandons the computation.
    in_valid = 1'b1;
    data_in  = DATA_W'(9);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    write_coef(9, 255);
    write_coef(15, 255);
    run_sample(200, 0, 1'b0, got);
    check("midrst_result", 64'(got), 64'(0));

    // Randomized mix of writes (some out of range), clears and samples.
    for (int it = 0; it < 60; it++) begin
      int unsigned r = $urandom_range(0, 9);
      if (r < 2) write_coef(int'($urandom_range(0, 15)), $urandom_range(0, 255));
      else if (r == 2) do_clear();
      else run_sample($urandom_range(0, 255), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
